// File: rtl/ball_handoff_ctrl.sv
// Ball hand-off sequencer: snapshots ball state at the screen edge, writes it to the peer over
// the I2C byte interface, then launches the ball the peer returns. Option: HANDOFF_RETRY_EN.
module ball_handoff_ctrl #(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned TIMEOUT_CYC = 25000,
  parameter int unsigned TO_W        = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       ball_exit,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [7:0] gravity,
  input  logic       collision,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [2:0] tx_addr,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       tx_nack,
  input  logic       rx_valid,
  input  logic [7:0] rx_y0,
  input  logic [7:0] rx_y1,
  input  logic [7:0] rx_vy,
  input  logic [7:0] rx_gravity,
  output logic       ball_launch,
  output logic [9:0] launch_y,
  output logic [7:0] launch_vy,
  output logic [7:0] launch_gravity,
  output logic       is_idle,
  output logic       is_transfer,
  output logic       is_waiting,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle, StPlay, StLatch, StSend, StWaitAck, StWaitRx, StLaunch
  } state_e;

  localparam logic [2:0]      LastIdx = 3'(NUM_REGS - 1);
  localparam logic [TO_W-1:0] ToLast  = TO_W'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [2:0]      idx_q;
  logic [TO_W-1:0] cnt_q;
  logic [7:0]      snap_q [NUM_REGS];
  logic [7:0]      snap_d [NUM_REGS];
  logic            fail, give_up, acked;
  logic            unused_rx_y1;

  assign unused_rx_y1 = ^rx_y1[7:2];

  // A nack wins over a simultaneous done.
  assign fail  = (state_q == StWaitAck) && (tx_nack || (cnt_q == ToLast));
  assign acked = (state_q == StWaitAck) && tx_done && !fail;

`ifdef HANDOFF_RETRY_EN
  logic [1:0] retry_q;
  assign give_up = fail && (retry_q == 2'd3);
`else
  assign give_up = fail;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) snap_d[i] = '0;
    snap_d[0] = ball_y[7:0];
    snap_d[1] = {6'b0, ball_y[9:8]};
    snap_d[2] = ball_vy;
    snap_d[3] = gravity;
    snap_d[4] = {7'b0, collision};
  end

  always_comb begin
    state_d = state_q;
    if (game_over) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (game_start)    state_d = StPlay;
          else if (rx_valid) state_d = StLaunch;
        end
        StPlay:    if (ball_exit) state_d = StLatch;
        StLatch:   state_d = StSend;
        StSend:    if (tx_ready) state_d = StWaitAck;
        StWaitAck: begin
          if (fail)       state_d = give_up ? StIdle : StSend;
          else if (acked) state_d = (idx_q == LastIdx) ? StWaitRx : StSend;
        end
        StWaitRx:  if (rx_valid) state_d = StLaunch;
        StLaunch:  state_d = StPlay;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      cnt_q          <= '0;
      for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= '0;
      tx_start       <= 1'b0;
      tx_addr        <= '0;
      tx_data        <= '0;
      ball_launch    <= 1'b0;
      launch_y       <= '0;
      launch_vy      <= '0;
      launch_gravity <= '0;
      is_idle        <= 1'b0;
      is_transfer    <= 1'b0;
      is_waiting     <= 1'b0;
      err            <= 1'b0;
`ifdef HANDOFF_RETRY_EN
      retry_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      is_idle     <= (state_d == StIdle);
      is_transfer <= (state_d == StSend) || (state_d == StWaitAck);
      is_waiting  <= (state_d == StWaitRx);
      ball_launch <= (state_d == StLaunch);
      tx_start    <= 1'b0;
      cnt_q       <= ((state_q == StWaitAck) && (state_d == StWaitAck)) ? cnt_q + 1'b1 : '0;

      if ((state_q == StPlay) && (state_d == StLatch)) snap_q <= snap_d;

      // addr/data stay put after the request until the next byte is issued
      if ((state_q == StSend) && (state_d == StWaitAck)) begin
        tx_start <= 1'b1;
        tx_addr  <= idx_q;
        tx_data  <= snap_q[idx_q];
      end

      if ((state_d == StIdle) || (state_q == StLatch)) idx_q <= '0;
      else if (acked && (idx_q != LastIdx))            idx_q <= idx_q + 3'd1;

      if (state_d == StLaunch) begin
        launch_y       <= {rx_y1[1:0], rx_y0};
        launch_vy      <= rx_vy;
        launch_gravity <= rx_gravity;
      end

      if ((state_q == StIdle) && (state_d == StPlay)) err <= 1'b0;
      else if (give_up && !game_over)                 err <= 1'b1;

`ifdef HANDOFF_RETRY_EN
      if ((state_d == StIdle) || (state_q == StLatch) || acked) retry_q <= '0;
      else if (fail && !game_over)                              retry_q <= retry_q + 2'd1;
`endif
    end
  end

endmodule

// File: tb/tb_ball_handoff_ctrl.sv
// Self-checking bench for ball_handoff_ctrl; expectations follow HANDOFF_RETRY_EN when defined.
`timescale 1ns/1ps
module tb_ball_handoff_ctrl;

  localparam int NUM_REGS    = 5;
  localparam int TIMEOUT_CYC = 16;
  localparam int TO_W        = 15;
`ifdef HANDOFF_RETRY_EN
  localparam int RETRIES = 3;
`else
  localparam int RETRIES = 0;
`endif
  // each retry re-enters WAIT_ACK one SEND cycle after the previous timeout
  localparam int EXP_TO = TIMEOUT_CYC + RETRIES * (TIMEOUT_CYC + 1);

  logic       clk = 1'b0, reset = 1'b0;
  logic       game_start = 0, game_over = 0, ball_exit = 0, collision = 0;
  logic [9:0] ball_y = '0;
  logic [7:0] ball_vy = '0, gravity = '0;
  logic       tx_ready = 0, tx_done = 0, tx_nack = 0, rx_valid = 0;
  logic [7:0] rx_y0 = '0, rx_y1 = '0, rx_vy = '0, rx_gravity = '0;
  logic       tx_start, ball_launch, is_idle, is_transfer, is_waiting, err;
  logic [2:0] tx_addr;
  logic [7:0] tx_data, launch_vy, launch_gravity;
  logic [9:0] launch_y;

  int vec = 0, miss = 0, n_start = 0;

  ball_handoff_ctrl #(
    .NUM_REGS(NUM_REGS), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset(reset), .game_start(game_start), .game_over(game_over),
    .ball_exit(ball_exit), .ball_y(ball_y), .ball_vy(ball_vy), .gravity(gravity),
    .collision(collision), .tx_ready(tx_ready), .tx_start(tx_start), .tx_addr(tx_addr),
    .tx_data(tx_data), .tx_done(tx_done), .tx_nack(tx_nack), .rx_valid(rx_valid),
    .rx_y0(rx_y0), .rx_y1(rx_y1), .rx_vy(rx_vy), .rx_gravity(rx_gravity),
    .ball_launch(ball_launch), .launch_y(launch_y), .launch_vy(launch_vy),
    .launch_gravity(launch_gravity), .is_idle(is_idle), .is_transfer(is_transfer),
    .is_waiting(is_waiting), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (tx_start === 1'b1) n_start++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_start;
    @(negedge clk) game_start = 1;
    @(negedge clk) game_start = 0;
  endtask

  task automatic wait_tx_start(input bit jitter, output bit got, output logic [2:0] a,
                               output logic [7:0] d);
    got = 0; a = '0; d = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        got = 1; a = tx_addr; d = tx_data; tx_ready = 1;
        break;
      end
      tx_ready = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  // Drives one hand-off from PLAY, acting as the I2C master; byte nack_byte is nacked n_nack times.
  task automatic run_transfer(input logic [9:0] y, input logic [7:0] vy, input logic [7:0] g,
                              input logic col, input int nack_byte, input int n_nack,
                              input int dly_max, input bit rnd);
    logic [7:0] exp [NUM_REGS];
    bit got; logic [2:0] a; logic [7:0] d; int s0, dly, tries;
    exp[0] = y[7:0]; exp[1] = {6'b0, y[9:8]}; exp[2] = vy; exp[3] = g; exp[4] = {7'b0, col};
    @(negedge clk);
    ball_y = y; ball_vy = vy; gravity = g; collision = col; ball_exit = 1; tx_ready = 1;
    @(negedge clk);
    ball_exit = 0;
    if (rnd) begin
      ball_y = 10'($urandom); ball_vy = 8'($urandom); gravity = 8'($urandom);
      collision = 1'($urandom);
    end
    s0 = n_start;
    for (int b = 0; b < NUM_REGS; b++) begin
      tries = (b == nack_byte) ? n_nack + 1 : 1;
      for (int s = 0; s < tries; s++) begin
        wait_tx_start(rnd, got, a, d);
        vec++;
        if (!got || a !== 3'(b) || d !== exp[b] || is_transfer !== 1'b1) begin
          miss++;
          $display("FAIL byte%0d try%0d: seen=%0b addr=%0d data=%02h xfer=%b, want addr=%0d data=%02h xfer=1",
                   b, s, got, a, d, is_transfer, b, exp[b]);
        end
        dly = rnd ? int'($urandom_range(0, dly_max)) : dly_max;
        repeat (dly) @(negedge clk);
        if (s < tries - 1 || (b == nack_byte && n_nack > s)) begin
          tx_nack = 1;
          @(negedge clk) tx_nack = 0;
          if (s >= RETRIES) begin
            vec++;
            if (err !== 1'b1 || is_idle !== 1'b1) begin
              miss++;
              $display("FAIL nack_abort: err=%b idle=%b, want err=1 idle=1", err, is_idle);
            end
            return;
          end
        end else begin
          tx_done = 1;
          @(negedge clk) tx_done = 0;
        end
      end
    end
    vec++;
    if (is_waiting !== 1'b1 || err !== 1'b0 || n_start - s0 != NUM_REGS + n_nack) begin
      miss++;
      $display("FAIL xfer_end: waiting=%b err=%b starts=%0d, want waiting=1 err=0 starts=%0d",
               is_waiting, err, n_start - s0, NUM_REGS + n_nack);
    end
  endtask

  // Peer frame arrives while WAIT_RX; caller sits at a falling edge.
  task automatic do_launch(input logic [7:0] y0, input logic [7:0] y1, input logic [7:0] vy,
                           input logic [7:0] g);
    logic [9:0] ey;
    ey = {y1[1:0], y0};
    rx_y0 = y0; rx_y1 = y1; rx_vy = vy; rx_gravity = g; rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
    rx_y0 = 8'($urandom); rx_y1 = 8'($urandom); rx_vy = 8'($urandom); rx_gravity = 8'($urandom);
    vec++;
    if (ball_launch !== 1'b1 || launch_y !== ey || launch_vy !== vy || launch_gravity !== g) begin
      miss++;
      $display("FAIL launch: pulse=%b y=%03h vy=%02h g=%02h, want pulse=1 y=%03h vy=%02h g=%02h",
               ball_launch, launch_y, launch_vy, launch_gravity, ey, vy, g);
    end
    @(negedge clk);
    vec++;
    if (ball_launch !== 1'b0 || launch_y !== ey || launch_vy !== vy || is_idle !== 1'b0 ||
        is_waiting !== 1'b0 || is_transfer !== 1'b0) begin
      miss++;
      $display("FAIL launch_after: pulse=%b y=%03h vy=%02h flags=%b%b%b, want pulse=0 y=%03h vy=%02h flags=000",
               ball_launch, launch_y, launch_vy, is_idle, is_transfer, is_waiting, ey, vy);
    end
  endtask

  task automatic test_reset;
    #2 reset = 1;
    #1;
    vec++;
    if ({tx_start, tx_addr, tx_data, ball_launch, launch_y, launch_vy, launch_gravity,
         is_idle, is_transfer, is_waiting, err} !== '0) begin
      miss++;
      $display("FAIL reset_outputs: some output nonzero (idle=%b start=%b err=%b), want all 0",
               is_idle, tx_start, err);
    end
    @(negedge clk) reset = 0;
    @(negedge clk);
    vec++;
    if (is_idle !== 1'b1 || is_transfer !== 1'b0 || is_waiting !== 1'b0 || err !== 1'b0) begin
      miss++;
      $display("FAIL reset_idle: idle=%b xfer=%b wait=%b err=%b, want 1 0 0 0",
               is_idle, is_transfer, is_waiting, err);
    end
  endtask

  task automatic test_handoff;
    pulse_start();
    vec++;
    if (is_idle !== 1'b0) begin
      miss++;
      $display("FAIL play_entry: idle=%b, want 0", is_idle);
    end
    run_transfer(10'h2A5, 8'hFC, 8'h02, 1'b1, -1, 0, 3, 1'b0);
  endtask

  task automatic test_launch;
    do_launch(8'h10, 8'h01, 8'h05, 8'h01);
  endtask

  task automatic test_nack;
    int s0;
    run_transfer(10'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 2,
                 (RETRIES == 0) ? 1 : 3, 2, 1'b1);
    s0 = n_start;
    repeat (10) @(negedge clk);
    vec++;
    if (n_start != s0) begin
      miss++;
      $display("FAIL nack_quiet: extra starts=%0d, want 0", n_start - s0);
    end
  endtask

  task automatic test_timeout;
    bit got; logic [2:0] a; logic [7:0] d; int k, s0;
    @(negedge clk) game_over = 1;
    @(negedge clk) game_over = 0;
    vec++;
    if (is_idle !== 1'b1) begin
      miss++;
      $display("FAIL over_idle: idle=%b, want 1", is_idle);
    end
    pulse_start();
    vec++;
    if (err !== 1'b0 || is_idle !== 1'b0) begin
      miss++;
      $display("FAIL start_clears: err=%b idle=%b, want 0 0", err, is_idle);
    end
    tx_ready = 1;
    @(negedge clk) ball_exit = 1;
    @(negedge clk) ball_exit = 0;
    wait_tx_start(1'b0, got, a, d);
    k = 0;
    while (err !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    vec++;
    if (!got || k != EXP_TO || is_idle !== 1'b1) begin
      miss++;
      $display("FAIL timeout: seen=%0b cycles=%0d idle=%b, want seen=1 cycles=%0d idle=1",
               got, k, is_idle, EXP_TO);
    end
    tx_done = 1;
    @(negedge clk) tx_done = 0;
    s0 = n_start;
    repeat (6) @(negedge clk);
    vec++;
    if (n_start != s0 || is_idle !== 1'b1 || err !== 1'b1) begin
      miss++;
      $display("FAIL late_done: starts=%0d idle=%b err=%b, want 0 1 1", n_start - s0, is_idle, err);
    end
  endtask

  task automatic test_game_over;
    bit got; logic [2:0] a; logic [7:0] d; int s0;
    logic [7:0] g;
    g = 8'($urandom);
    pulse_start();
    vec++;
    if (err !== 1'b0) begin
      miss++;
      $display("FAIL err_clear: err=%b, want 0", err);
    end
    tx_ready = 1; gravity = g;
    @(negedge clk) ball_exit = 1;
    @(negedge clk) ball_exit = 0;
    for (int b = 0; b < 3; b++) begin
      wait_tx_start(1'b0, got, a, d);
      @(negedge clk) tx_done = 1;
      @(negedge clk) tx_done = 0;
    end
    wait_tx_start(1'b0, got, a, d);
    vec++;
    if (!got || a !== 3'd3 || d !== g) begin
      miss++;
      $display("FAIL byte3: seen=%0b addr=%0d data=%02h, want addr=3 data=%02h", got, a, d, g);
    end
    game_over = 1;
    @(negedge clk) game_over = 0;
    vec++;
    if (is_idle !== 1'b1 || tx_start !== 1'b0 || is_transfer !== 1'b0) begin
      miss++;
      $display("FAIL over_mid: idle=%b start=%b xfer=%b, want 1 0 0", is_idle, tx_start, is_transfer);
    end
    tx_done = 1;
    @(negedge clk) tx_done = 0;
    s0 = n_start;
    repeat (8) @(negedge clk);
    vec++;
    if (n_start != s0 || is_idle !== 1'b1) begin
      miss++;
      $display("FAIL over_quiet: starts=%0d idle=%b, want 0 1", n_start - s0, is_idle);
    end
    pulse_start();
    vec++;
    if (is_idle !== 1'b0 || err !== 1'b0 || is_waiting !== 1'b0) begin
      miss++;
      $display("FAIL restart: idle=%b err=%b wait=%b, want 0 0 0", is_idle, err, is_waiting);
    end
  endtask

  task automatic test_random;
    int nn;
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      rx_y0 = 8'($urandom); rx_vy = 8'($urandom); rx_valid = 1;
      @(negedge clk) rx_valid = 0;
      vec++;
      if (ball_launch !== 1'b0 || is_idle !== 1'b0) begin
        miss++;
        $display("FAIL rx_in_play: launch=%b idle=%b, want 0 0", ball_launch, is_idle);
      end
      nn = (RETRIES > 0) ? int'($urandom_range(0, RETRIES)) : 0;
      run_transfer(10'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, NUM_REGS - 1)), nn, 4, 1'b1);
      do_launch(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_reset_mid;
    int s0;
    tx_ready = 0;
    @(negedge clk) ball_exit = 1;
    @(negedge clk) ball_exit = 0;
    @(negedge clk);
    vec++;
    if (is_transfer !== 1'b1) begin
      miss++;
      $display("FAIL send_stall: xfer=%b, want 1", is_transfer);
    end
    #2 reset = 1;
    #1;
    vec++;
    if ({tx_start, tx_addr, tx_data, ball_launch, launch_y, launch_vy, launch_gravity,
         is_idle, is_transfer, is_waiting, err} !== '0) begin
      miss++;
      $display("FAIL reset_mid: outputs nonzero (xfer=%b y=%03h), want all 0", is_transfer, launch_y);
    end
    @(negedge clk) reset = 0;
    tx_ready = 1;
    s0 = n_start;
    @(negedge clk) ball_exit = 1;
    @(negedge clk) ball_exit = 0;
    repeat (10) @(negedge clk);
    vec++;
    if (n_start != s0 || is_idle !== 1'b1 || is_transfer !== 1'b0) begin
      miss++;
      $display("FAIL exit_in_idle: starts=%0d idle=%b xfer=%b, want 0 1 0",
               n_start - s0, is_idle, is_transfer);
    end
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_launch();
    test_nack();
    test_timeout();
    test_game_over();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
